// File: rtl/bsg_mem_1rw_sync_mask_write_bit_banked_init.sv
// bsg_mem_1rw_sync_mask_write_bit_banked_init
// Single-port synchronous memory with per-bit write masks. Rows are split
// across num_banks_p low-order-interleaved banks. Requests use a
// valid/ready handshake, and read data comes back one cycle later with v_o.
// After reset, or on clear_i, a built-in engine writes init_val_p into every
// row. It writes one row of every bank per cycle, in parallel.
// Optional build macro: BSG_MEM_ADDR_RANGE_CHECK_EN. When it is defined, an
// accepted request with addr_i >= els_p raises a sticky err_o. That request
// leaves the array untouched, and a read from it returns zero.
module bsg_mem_1rw_sync_mask_write_bit_banked_init #(
  parameter int                 width_p           = 64,
  parameter int                 els_p             = 128,
  parameter int                 num_banks_p       = 2,
  parameter logic [width_p-1:0] init_val_p        = '0,
  parameter int                 latch_last_read_p = 1,
  localparam int                addr_width_lp     = (els_p > 1) ? $clog2(els_p) : 1
) (
  input  logic                     clk_i,
  input  logic                     reset_n_i,
  input  logic                     clear_i,
  input  logic                     v_i,
  output logic                     ready_o,
  input  logic                     w_i,
  input  logic [addr_width_lp-1:0] addr_i,
  input  logic [width_p-1:0]       data_i,
  input  logic [width_p-1:0]       w_mask_i,
  output logic                     v_o,
  output logic [width_p-1:0]       data_o,
  output logic                     err_o
);

  localparam int lg_banks_lp  = (num_banks_p > 1) ? $clog2(num_banks_p) : 0;
  localparam int sel_width_lp = (lg_banks_lp > 0) ? lg_banks_lp : 1;
  localparam int rows_lp      = els_p / num_banks_p;
  localparam int row_width_lp = (rows_lp > 1) ? $clog2(rows_lp) : 1;
  localparam logic [row_width_lp-1:0] last_row_lp = row_width_lp'(rows_lp - 1);

  typedef enum logic {INIT_S = 1'b0, READY_S = 1'b1} state_e;

  state_e                    state_q, state_d;
  logic [row_width_lp-1:0]   cnt_q, cnt_d;
  logic                      init_w;
  logic                      accept;
  logic                      rd_accept;
  logic                      oor;
  logic [sel_width_lp-1:0]   req_bank;
  logic [row_width_lp-1:0]   req_row;
  logic [row_width_lp-1:0]   mem_addr;
  logic [width_p-1:0]        mem_wdata;
  logic [width_p-1:0]        mem_wmask;
  logic [num_banks_p-1:0][width_p-1:0] bank_rd;
  logic                      v_q;
  logic [sel_width_lp-1:0]   sel_q;
  logic                      zero_q;
  logic [width_p-1:0]        rd_mux;

  // Split the address: the low bits pick the bank, the upper bits pick the row in that bank
  generate
    if (lg_banks_lp == 0) begin : g_one_bank
      assign req_bank = '0;
      assign req_row  = addr_i[row_width_lp-1:0];
    end else begin : g_multi_bank
      assign req_bank = addr_i[lg_banks_lp-1:0];
      assign req_row  = addr_i[lg_banks_lp +: row_width_lp];
    end
  endgenerate

  // FSM state register and the init row counter
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= INIT_S;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // FSM next state: sweep every row once, then serve requests until the next clear
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      INIT_S: begin
        if (clear_i) begin
          cnt_d = '0;
        end else if (cnt_q == last_row_lp) begin
          state_d = READY_S;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        if (clear_i) begin
          state_d = INIT_S;
          cnt_d   = '0;
        end
      end
    endcase
  end

  // FSM outputs: ready is decoded from the registered state only
  always_comb begin
    ready_o = (state_q == READY_S);
    init_w  = (state_q == INIT_S);
  end

  assign accept    = v_i & ready_o;
  assign rd_accept = accept & ~w_i & ~oor;

`ifdef BSG_MEM_ADDR_RANGE_CHECK_EN
  localparam logic [addr_width_lp:0] els_ext_lp = (addr_width_lp + 1)'(els_p);
  logic err_q;

  assign oor = ({1'b0, addr_i} >= els_ext_lp);

  // Sticky error flag for out-of-range requests, cleared by reset or clear
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      err_q <= 1'b0;
    end else if (clear_i) begin
      err_q <= 1'b0;
    end else if (accept && oor) begin
      err_q <= 1'b1;
    end
  end

  assign err_o = err_q;
`else
  assign oor   = 1'b0;
  assign err_o = 1'b0;
`endif

  // Init writes full rows of init_val_p at the counter; otherwise the request drives the port
  always_comb begin
    mem_addr  = init_w ? cnt_q : req_row;
    mem_wdata = init_w ? init_val_p : data_i;
    mem_wmask = init_w ? {width_p{1'b1}} : w_mask_i;
  end

  generate
    for (genvar gi = 0; gi < num_banks_p; gi++) begin : g_bank
      logic [width_p-1:0] mem_q [rows_lp];
      logic [width_p-1:0] rd_q;
      logic               bank_hit;
      logic               we;
      logic               re;

      assign bank_hit = accept & ~oor & (req_bank == sel_width_lp'(gi));
      assign we       = init_w | (bank_hit & w_i);
      assign re       = bank_hit & ~w_i;

      // Bit-masked write and registered read. rd_q changes only on a read to this bank
      always_ff @(posedge clk_i) begin
        if (we) begin
          for (int b = 0; b < width_p; b++) begin
            if (mem_wmask[b]) mem_q[mem_addr][b] <= mem_wdata[b];
          end
        end
        if (re) begin
          rd_q <= mem_q[mem_addr];
        end
      end

      assign bank_rd[gi] = rd_q;
    end
  endgenerate

  // Read-response bookkeeping: valid pulse, which bank answered, and whether the answer is forced to zero
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      v_q    <= 1'b0;
      sel_q  <= '0;
      zero_q <= 1'b1;
    end else begin
      v_q <= accept & ~w_i;
      if (accept && !w_i) begin
        sel_q  <= req_bank;
        zero_q <= oor;
      end
    end
  end

  assign v_o    = v_q;
  assign rd_mux = bank_rd[sel_q];

  // The output either holds the last response or shows data only while v_o is high
  always_comb begin
    if (latch_last_read_p != 0) begin
      data_o = zero_q ? '0 : rd_mux;
    end else begin
      data_o = (v_q && !zero_q) ? rd_mux : '0;
    end
  end

  // rd_accept documents the in-range read path; the bank enables use the same terms
  logic unused_rd_accept;
  assign unused_rd_accept = rd_accept;

endmodule
